// File: rtl/apb_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_pkg
// Description : Shared types and constants for the APB4 register-file slave.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_slave_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_e;

    localparam logic [31:0] c_default_id = 32'hA9B0_0001;
    localparam int          c_err_cnt_w  = 8;
    localparam int          c_wait_w     = 4;

endpackage
`default_nettype wire

// File: rtl/apb_wait_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : apb_wait_ctrl
// Description : APB transfer FSM with programmable wait-state insertion.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_wait_ctrl
    import apb_slave_pkg::*;
(
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                i_psel,
    input  logic                i_penable,
    input  logic [c_wait_w-1:0] i_wait_cfg,
    output logic                o_pready
);

    apb_state_e          r_state;
    apb_state_e          w_state_nxt;
    logic [c_wait_w-1:0] r_cnt;
    logic [c_wait_w-1:0] w_cnt_nxt;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // wait_cfg is sampled only on the setup edge; any exit from ACCESS clears the counter
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (i_psel && !i_penable) begin
                    w_state_nxt = ST_ACCESS;
                    w_cnt_nxt   = i_wait_cfg;
                end
            end
            ST_ACCESS: begin
                if (!i_psel || !i_penable || (r_cnt == '0)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        o_pready = (r_state == ST_ACCESS) && (r_cnt == '0);
    end

endmodule
`default_nettype wire

// File: rtl/apb4_regfile_slave.sv
`default_nettype none
// ============================================================================
// Module      : apb4_regfile_slave
// Description : APB4 register file with byte strobes, wait states and errors.
// Revision    : 1.0 - initial release
// ============================================================================
module apb4_regfile_slave
    import apb_slave_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int          NUM_REGS   = 16,
    parameter logic [31:0] ID_VALUE   = c_default_id
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [c_wait_w-1:0]     wait_cfg,
    output logic                    PREADY,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PSLVERR,
    output logic [c_err_cnt_w-1:0]  err_cnt
);

    localparam int                c_bytes = DATA_WIDTH / 8;
    localparam int                c_b     = $clog2(c_bytes);
    localparam int                c_idx_w = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH:0] c_span = (ADDR_WIDTH+1)'(NUM_REGS * c_bytes);

    logic                   w_pready;
    logic                   w_xfer_done;
    logic                   w_oor;
    logic                   w_err;
    logic                   w_wr_en;
    logic [c_idx_w-1:0]     w_idx;
    logic [DATA_WIDTH-1:0]  w_regfile [NUM_REGS];
    logic [c_err_cnt_w-1:0] r_err_cnt;

    apb_wait_ctrl u_wait_ctrl (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .i_psel     (PSEL),
        .i_penable  (PENABLE),
        .i_wait_cfg (wait_cfg),
        .o_pready   (w_pready)
    );

    assign w_idx       = PADDR[c_idx_w+c_b-1:c_b];
    assign w_oor       = ({1'b0, PADDR} >= c_span);
    assign w_err       = w_oor || (PWRITE && (w_idx == '0));
    assign w_xfer_done = PSEL && PENABLE && w_pready;
    assign w_wr_en     = w_xfer_done && PWRITE && !w_err;

    assign PREADY  = w_pready;
    assign PSLVERR = w_xfer_done && w_err;
    assign PRDATA  = (w_xfer_done && !PWRITE && !w_err) ? w_regfile[w_idx] : '0;
    assign err_cnt = r_err_cnt;

    // Register 0 is a hard-wired identification word
    assign w_regfile[0] = ID_VALUE[DATA_WIDTH-1:0];

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
        logic [DATA_WIDTH-1:0] r_data;

        always_ff @(posedge PCLK or negedge PRESETn) begin
            if (!PRESETn) begin
                r_data <= '0;
            end else if (w_wr_en && (w_idx == c_idx_w'(i))) begin
                for (int k = 0; k < c_bytes; k++) begin
                    if (PSTRB[k]) begin
                        r_data[8*k +: 8] <= PWDATA[8*k +: 8];
                    end
                end
            end
        end

        assign w_regfile[i] = r_data;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_err_cnt <= '0;
        end else if (PSLVERR && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb4_regfile_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb4_regfile_slave
// Description : Scoreboard bench for the APB4 register-file slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb4_regfile_slave;

    localparam logic [31:0] c_id = 32'hA9B0_0001;

    logic        PCLK     = 1'b0;
    logic        PRESETn  = 1'b0;
    logic        PSEL     = 1'b0;
    logic        PENABLE  = 1'b0;
    logic        PWRITE   = 1'b0;
    logic [31:0] PADDR    = '0;
    logic [31:0] PWDATA   = '0;
    logic [3:0]  PSTRB    = '0;
    logic [3:0]  wait_cfg = '0;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;
    logic [7:0]  err_cnt;

    apb4_regfile_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_REGS   (16),
        .ID_VALUE   (c_id)
    ) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PSTRB    (PSTRB),
        .wait_cfg (wait_cfg),
        .PREADY   (PREADY),
        .PRDATA   (PRDATA),
        .PSLVERR  (PSLVERR),
        .err_cnt  (err_cnt)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          waits;
    } exp_t;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   mon_waits = 0;
    int   exp_errs  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per completed transfer
    always @(negedge PCLK) begin : mon
        exp_t e;
        if (!PRESETn) begin
            mon_waits = 0;
        end else if (PSEL && PENABLE) begin
            if (PREADY) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_completion: PREADY=1, no transfer expected");
                end else begin
                    e = sb.pop_front();
                    chk("prdata", PRDATA, e.rdata);
                    chk("pslverr", 32'(PSLVERR), 32'(e.err));
                    chk("wait_states", 32'(mon_waits), 32'(e.waits));
                end
                mon_waits = 0;
            end else begin
                chk("prdata_while_waiting", PRDATA, 32'h0);
                chk("pslverr_while_waiting", 32'(PSLVERR), 32'h0);
                mon_waits++;
            end
        end else begin
            mon_waits = 0;
        end
    end

    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [3:0] wt,
                        input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        int   n;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.waits = int'(wt);
        sb.push_back(e);
        if (exp_err) exp_errs = (exp_errs == 255) ? 255 : exp_errs + 1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr;
        PWDATA = data; PSTRB = strb; wait_cfg = wt;
        @(posedge PCLK); #1;
        PENABLE  = 1'b1;
        wait_cfg = ~wt;
        n = 0;
        while (!PREADY && n < 40) begin
            @(posedge PCLK); #1;
            n++;
        end
        if (!PREADY) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: PREADY=0 after 40 cycles, expected 1");
            void'(sb.pop_back());
        end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; wait_cfg = '0;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge PCLK);
        #1;
        chk("reset_pready", 32'(PREADY), 32'h0);
        chk("reset_prdata", PRDATA, 32'h0);
        chk("reset_pslverr", 32'(PSLVERR), 32'h0);
        chk("reset_err_cnt", 32'(err_cnt), 32'h0);

        // First setup immediately after reset release
        PRESETn = 1'b1;
        xfer(1'b1, 32'h4, 32'hDEAD_BEEF, 4'hF, 4'd0, 32'h0, 1'b0);
        xfer(1'b0, 32'h4, 32'h0, 4'h0, 4'd0, 32'hDEAD_BEEF, 1'b0);
        xfer(1'b0, 32'h0, 32'h0, 4'h0, 4'd3, c_id, 1'b0);

        xfer(1'b1, 32'h8, 32'h1122_3344, 4'hF, 4'd0, 32'h0, 1'b0);
        xfer(1'b1, 32'h8, 32'hFFFF_FFFF, 4'b0101, 4'd1, 32'h0, 1'b0);
        xfer(1'b0, 32'h8, 32'h0, 4'h0, 4'd2, 32'h11FF_33FF, 1'b0);

        // Zero strobe, ignored low address bits, last valid register
        xfer(1'b1, 32'h4, 32'h0, 4'h0, 4'd0, 32'h0, 1'b0);
        xfer(1'b0, 32'h5, 32'h0, 4'h0, 4'd0, 32'hDEAD_BEEF, 1'b0);
        xfer(1'b0, 32'h3C, 32'h0, 4'h0, 4'd0, 32'h0, 1'b0);

        // Error responses
        xfer(1'b1, 32'h0, 32'h1234_5678, 4'hF, 4'd0, 32'h0, 1'b1);
        xfer(1'b0, 32'h40, 32'h0, 4'h0, 4'd0, 32'h0, 1'b1);
        xfer(1'b0, 32'h0, 32'h0, 4'h0, 4'd0, c_id, 1'b0);
        chk("err_cnt_after_two_errors", 32'(err_cnt), 32'd2);

        // Protocol violation: PENABLE high while idle
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 32'h0;
        repeat (2) begin
            @(posedge PCLK); #1;
            chk("pready_on_violation", 32'(PREADY), 32'h0);
        end
        PSEL = 1'b0; PENABLE = 1'b0;
        xfer(1'b1, 32'hC, 32'hCAFE_F00D, 4'hF, 4'd0, 32'h0, 1'b0);

        // Abort a long write part-way through
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'hC;
        PWDATA = 32'h1234_5678; PSTRB = 4'hF; wait_cfg = 4'd5;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        repeat (2) @(posedge PCLK);
        #1;
        chk("pready_before_abort", 32'(PREADY), 32'h0);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        xfer(1'b0, 32'hC, 32'h0, 4'h0, 4'd0, 32'hCAFE_F00D, 1'b0);
        chk("err_cnt_after_abort", 32'(err_cnt), 32'd2);

        // Saturate the error counter
        for (int i = 0; i < 256; i++) begin
            xfer(1'b0, 32'h100 + 32'(4 * (i % 4)), 32'h0, 4'h0, 4'd0, 32'h0, 1'b1);
        end
        chk("err_cnt_saturated", 32'(err_cnt), 32'(exp_errs));

        // Reset in the middle of a write
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'hC;
        PWDATA = 32'hFFFF_FFFF; PSTRB = 4'hF; wait_cfg = 4'd2;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PRESETn = 1'b0;
        #1;
        chk("midreset_pready", 32'(PREADY), 32'h0);
        chk("midreset_prdata", PRDATA, 32'h0);
        chk("midreset_pslverr", 32'(PSLVERR), 32'h0);
        chk("midreset_err_cnt", 32'(err_cnt), 32'h0);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        xfer(1'b0, 32'hC, 32'h0, 4'h0, 4'd0, 32'h0, 1'b0);
        xfer(1'b0, 32'h0, 32'h0, 4'h0, 4'd1, c_id, 1'b0);

        repeat (2) @(posedge PCLK);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
